// File: rtl/bsg_link_bist_pkg.sv
// bsg_link_bist_pkg
// Shared types for the link BIST hub. Imported by the per-channel block and the
// top level.
//   mode_e  : per-channel run-time mode (PASS / LOOP / GEN / CHECK)
//   state_e : per-channel mode-change state (RUN / DRAIN)
package bsg_link_bist_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_LOOP  = 2'd1,
        MODE_GEN   = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/bsg_link_bist_channel.sv
// bsg_link_bist_two_fifo + bsg_link_bist_channel
//
// bsg_link_bist_two_fifo: 2-entry ready/valid FIFO. ready_o is "not full" and
// v_o is "not empty", both purely from registered state, so neither output
// depends combinationally on the other side's handshake.
//   v_i/data_i/ready_o : enqueue side, a push happens on v_i & ready_o
//   v_o/data_o/yumi_i  : dequeue side, a pop happens on v_o & yumi_i
//
// bsg_link_bist_channel: one hub channel. Holds the inbound FIFO A, the
// outbound FIFO B, the RUN/DRAIN mode FSM, the pattern generator, the checker
// and the saturating status counters.
//   cfg_v_i/cfg_mode_i      : mode-write strobe and requested mode
//   link_* / core_*         : ready/valid channels, a transfer is v & ready at
//                             the rising edge of clk_i
//   mode_o, busy_o          : active mode, busy_o = FSM is in DRAIN
//   locked_o                : checker has seen its first word
//   sent/recv/err_cnt_o     : saturating status counters
//   first_err_*_o           : only with BSG_LINK_BIST_FIRST_ERR_EN defined;
//                             received/expected words of the first mismatch
module bsg_link_bist_two_fifo #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] mem_r [2];
    logic               rd_ptr_r, wr_ptr_r;
    logic [1:0]         count_r;
    logic               enq, deq;

    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[rd_ptr_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (enq) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (deq) rd_ptr_r <= ~rd_ptr_r;
            case ({enq, deq})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module bsg_link_bist_channel
    import bsg_link_bist_pkg::*;
#(
    parameter int          width_p     = 32,
    parameter logic [31:0] seed_p      = 32'h0000_0100,
    parameter int          cnt_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   cfg_v_i,
    input  logic [1:0]             cfg_mode_i,
    input  logic                   link_v_i,
    input  logic [width_p-1:0]     link_data_i,
    output logic                   link_ready_o,
    output logic                   link_v_o,
    output logic [width_p-1:0]     link_data_o,
    input  logic                   link_ready_i,
    input  logic                   core_v_i,
    input  logic [width_p-1:0]     core_data_i,
    output logic                   core_ready_o,
    output logic                   core_v_o,
    output logic [width_p-1:0]     core_data_o,
    input  logic                   core_ready_i,
    output logic [1:0]             mode_o,
    output logic                   busy_o,
    output logic                   locked_o,
    output logic [cnt_width_p-1:0] sent_cnt_o,
    output logic [cnt_width_p-1:0] recv_cnt_o,
`ifdef BSG_LINK_BIST_FIRST_ERR_EN
    output logic                   first_err_v_o,
    output logic [width_p-1:0]     first_err_data_o,
    output logic [width_p-1:0]     first_err_exp_o,
`endif
    output logic [cnt_width_p-1:0] err_cnt_o
);
    localparam logic [width_p-1:0] seed_lp = width_p'(seed_p);

    mode_e  mode_r, mode_n, pend_r, pend_n;
    state_e state_r, state_n;

    logic               a_v_in, a_ready, a_v, a_yumi;
    logic [width_p-1:0] a_data;
    logic               b_v_in, b_ready, b_v, b_yumi;
    logic [width_p-1:0] b_data, b_data_in;

    logic [width_p-1:0]     gen_idx_r, exp_r;
    logic [cnt_width_p-1:0] sent_r, recv_r, err_r;
    logic                   locked_r;
    logic run, drain_done, gen_push, link_in_xfer, link_out_xfer, chk_word, chk_miss;

    assign run        = (state_r == ST_RUN);
    assign drain_done = (state_r == ST_DRAIN) & ~a_v & ~b_v;

    // Mode FSM: state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_RUN;
            mode_r  <= MODE_PASS;
            pend_r  <= MODE_PASS;
        end else begin
            state_r <= state_n;
            mode_r  <= mode_n;
            pend_r  <= pend_n;
        end
    end

    // Mode FSM: next state. A write on the same cycle the drain completes
    // still wins, since pend_n already carries it.
    always_comb begin
        state_n = state_r;
        mode_n  = mode_r;
        pend_n  = pend_r;
        case (state_r)
            ST_RUN: begin
                if (cfg_v_i) begin
                    pend_n  = mode_e'(cfg_mode_i);
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cfg_v_i) pend_n = mode_e'(cfg_mode_i);
                if (~a_v & ~b_v) begin
                    mode_n  = pend_n;
                    state_n = ST_RUN;
                end
            end
        endcase
    end

    // Routing. Every ready_o is built from FIFO occupancy and FSM state only,
    // and every v_o comes straight from a FIFO head, so there are no
    // combinational ready->ready or valid->valid paths. In DRAIN all inputs
    // are refused while the FIFO outputs keep draining.
    always_comb begin
        a_v_in       = 1'b0;
        a_yumi       = 1'b0;
        b_v_in       = 1'b0;
        b_yumi       = 1'b0;
        b_data_in    = core_data_i;
        link_ready_o = 1'b0;
        core_ready_o = 1'b0;
        link_v_o     = 1'b0;
        link_data_o  = '0;
        core_v_o     = 1'b0;
        core_data_o  = '0;
        case (mode_r)
            MODE_PASS: begin
                link_ready_o = run & a_ready;
                a_v_in       = link_v_i & run;
                core_v_o     = a_v;
                core_data_o  = a_data;
                a_yumi       = core_ready_i;
                core_ready_o = run & b_ready;
                b_v_in       = core_v_i & run;
                link_v_o     = b_v;
                link_data_o  = b_data;
                b_yumi       = link_ready_i;
            end
            MODE_LOOP: begin
                link_ready_o = run & a_ready;
                a_v_in       = link_v_i & run;
                link_v_o     = a_v;
                link_data_o  = a_data;
                a_yumi       = link_ready_i;
            end
            MODE_GEN: begin
                b_v_in      = run;
                b_data_in   = seed_lp + gen_idx_r;
                link_v_o    = b_v;
                link_data_o = b_data;
                b_yumi      = link_ready_i;
            end
            MODE_CHECK: begin
                link_ready_o = run;
            end
        endcase
    end

    bsg_link_bist_two_fifo #(.width_p(width_p)) u_fifo_a (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .v_i(a_v_in), .data_i(link_data_i), .ready_o(a_ready),
        .v_o(a_v), .data_o(a_data), .yumi_i(a_yumi)
    );

    bsg_link_bist_two_fifo #(.width_p(width_p)) u_fifo_b (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .v_i(b_v_in), .data_i(b_data_in), .ready_o(b_ready),
        .v_o(b_v), .data_o(b_data), .yumi_i(b_yumi)
    );

    assign gen_push      = (mode_r == MODE_GEN) & run & b_ready;
    assign link_in_xfer  = link_v_i & link_ready_o;
    assign link_out_xfer = link_v_o & link_ready_i;
    assign chk_word      = link_in_xfer & (mode_r == MODE_CHECK);
    assign chk_miss      = chk_word & locked_r & (link_data_i != exp_r);

    // Counters, generator index and checker state; all restart when a
    // drain completes. Every received word resyncs the expectation.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sent_r    <= '0;
            recv_r    <= '0;
            err_r     <= '0;
            locked_r  <= 1'b0;
            exp_r     <= '0;
            gen_idx_r <= '0;
        end else if (drain_done) begin
            sent_r    <= '0;
            recv_r    <= '0;
            err_r     <= '0;
            locked_r  <= 1'b0;
            exp_r     <= '0;
            gen_idx_r <= '0;
        end else begin
            if (link_out_xfer && mode_r == MODE_GEN && sent_r != '1)
                sent_r <= sent_r + cnt_width_p'(1);
            if (link_in_xfer && recv_r != '1) recv_r <= recv_r + cnt_width_p'(1);
            if (chk_miss && err_r != '1) err_r <= err_r + cnt_width_p'(1);
            if (chk_word) begin
                locked_r <= 1'b1;
                exp_r    <= link_data_i + width_p'(1);
            end
            if (gen_push) gen_idx_r <= gen_idx_r + width_p'(1);
        end
    end

`ifdef BSG_LINK_BIST_FIRST_ERR_EN
    logic               fe_v_r;
    logic [width_p-1:0] fe_data_r, fe_exp_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fe_v_r    <= 1'b0;
            fe_data_r <= '0;
            fe_exp_r  <= '0;
        end else if (drain_done) begin
            fe_v_r    <= 1'b0;
            fe_data_r <= '0;
            fe_exp_r  <= '0;
        end else if (chk_miss && !fe_v_r) begin
            fe_v_r    <= 1'b1;
            fe_data_r <= link_data_i;
            fe_exp_r  <= exp_r;
        end
    end

    assign first_err_v_o    = fe_v_r;
    assign first_err_data_o = fe_data_r;
    assign first_err_exp_o  = fe_exp_r;
`endif

    assign mode_o     = mode_r;
    assign busy_o     = (state_r == ST_DRAIN);
    assign locked_o   = locked_r;
    assign sent_cnt_o = sent_r;
    assign recv_cnt_o = recv_r;
    assign err_cnt_o  = err_r;
endmodule

// File: rtl/bsg_link_bist_hub.sv
// bsg_link_bist_hub
// Per-channel traffic hub between N link-side and N core-side ready/valid
// channels. Each channel runs PASS, LOOP, GEN or CHECK independently; see
// bsg_link_bist_channel. All per-channel ports are flattened, channel i
// occupying slice [i*w +: w] of each bus.
//   clk_i, reset_n_i (async, active-low)
//   cfg_v_i[N], cfg_mode_i[2N]         : mode writes
//   link_v_i/link_data_i/link_ready_o  : inbound from link
//   link_v_o/link_data_o/link_ready_i  : outbound to link
//   core_v_i/core_data_i/core_ready_o  : inbound from core
//   core_v_o/core_data_o/core_ready_i  : outbound to core
//   mode_o[2N], busy_o[N], locked_o[N], sent/recv/err_cnt_o[N*cnt]
// Optional: define BSG_LINK_BIST_FIRST_ERR_EN to add first_err_v_o,
// first_err_data_o and first_err_exp_o.
module bsg_link_bist_hub
    import bsg_link_bist_pkg::*;
#(
    parameter int          width_p        = 32,
    parameter int          num_channels_p = 4,
    parameter logic [31:0] seed_p         = 32'h0000_0100,
    parameter int          cnt_width_p    = 16
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_channels_p-1:0]           cfg_v_i,
    input  logic [2*num_channels_p-1:0]         cfg_mode_i,
    input  logic [num_channels_p-1:0]           link_v_i,
    input  logic [num_channels_p*width_p-1:0]   link_data_i,
    output logic [num_channels_p-1:0]           link_ready_o,
    output logic [num_channels_p-1:0]           link_v_o,
    output logic [num_channels_p*width_p-1:0]   link_data_o,
    input  logic [num_channels_p-1:0]           link_ready_i,
    input  logic [num_channels_p-1:0]           core_v_i,
    input  logic [num_channels_p*width_p-1:0]   core_data_i,
    output logic [num_channels_p-1:0]           core_ready_o,
    output logic [num_channels_p-1:0]           core_v_o,
    output logic [num_channels_p*width_p-1:0]   core_data_o,
    input  logic [num_channels_p-1:0]           core_ready_i,
    output logic [2*num_channels_p-1:0]         mode_o,
    output logic [num_channels_p-1:0]           busy_o,
    output logic [num_channels_p-1:0]           locked_o,
    output logic [num_channels_p*cnt_width_p-1:0] sent_cnt_o,
    output logic [num_channels_p*cnt_width_p-1:0] recv_cnt_o,
`ifdef BSG_LINK_BIST_FIRST_ERR_EN
    output logic [num_channels_p-1:0]           first_err_v_o,
    output logic [num_channels_p*width_p-1:0]   first_err_data_o,
    output logic [num_channels_p*width_p-1:0]   first_err_exp_o,
`endif
    output logic [num_channels_p*cnt_width_p-1:0] err_cnt_o
);
    for (genvar i = 0; i < num_channels_p; i++) begin : g_ch
        bsg_link_bist_channel #(
            .width_p(width_p), .seed_p(seed_p), .cnt_width_p(cnt_width_p)
        ) u_ch (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .cfg_v_i     (cfg_v_i[i]),
            .cfg_mode_i  (cfg_mode_i[2*i +: 2]),
            .link_v_i    (link_v_i[i]),
            .link_data_i (link_data_i[i*width_p +: width_p]),
            .link_ready_o(link_ready_o[i]),
            .link_v_o    (link_v_o[i]),
            .link_data_o (link_data_o[i*width_p +: width_p]),
            .link_ready_i(link_ready_i[i]),
            .core_v_i    (core_v_i[i]),
            .core_data_i (core_data_i[i*width_p +: width_p]),
            .core_ready_o(core_ready_o[i]),
            .core_v_o    (core_v_o[i]),
            .core_data_o (core_data_o[i*width_p +: width_p]),
            .core_ready_i(core_ready_i[i]),
            .mode_o      (mode_o[2*i +: 2]),
            .busy_o      (busy_o[i]),
            .locked_o    (locked_o[i]),
            .sent_cnt_o  (sent_cnt_o[i*cnt_width_p +: cnt_width_p]),
            .recv_cnt_o  (recv_cnt_o[i*cnt_width_p +: cnt_width_p]),
`ifdef BSG_LINK_BIST_FIRST_ERR_EN
            .first_err_v_o   (first_err_v_o[i]),
            .first_err_data_o(first_err_data_o[i*width_p +: width_p]),
            .first_err_exp_o (first_err_exp_o[i*width_p +: width_p]),
`endif
            .err_cnt_o   (err_cnt_o[i*cnt_width_p +: cnt_width_p])
        );
    end
endmodule

// File: tb/tb_bsg_link_bist_hub.sv
// Bench for bsg_link_bist_hub (default parameters: 4 channels, 32-bit data,
// seed 0x100, 16-bit counters). Inputs are driven and outputs sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_bsg_link_bist_hub;
    localparam int N = 4;
    localparam int W = 32;
    localparam int C = 16;

    logic           clk, reset_n;
    logic [N-1:0]   cfg_v_i;
    logic [2*N-1:0] cfg_mode_i;
    logic [N-1:0]   link_v_i, link_ready_o, link_v_o, link_ready_i;
    logic [N-1:0]   core_v_i, core_ready_o, core_v_o, core_ready_i;
    logic [N*W-1:0] link_data_i, link_data_o, core_data_i, core_data_o;
    logic [2*N-1:0] mode_o;
    logic [N-1:0]   busy_o, locked_o;
    logic [N*C-1:0] sent_cnt_o, recv_cnt_o, err_cnt_o;
`ifdef BSG_LINK_BIST_FIRST_ERR_EN
    logic [N-1:0]   first_err_v_o;
    logic [N*W-1:0] first_err_data_o, first_err_exp_o;
`endif

    bsg_link_bist_hub dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .cfg_v_i(cfg_v_i), .cfg_mode_i(cfg_mode_i),
        .link_v_i(link_v_i), .link_data_i(link_data_i), .link_ready_o(link_ready_o),
        .link_v_o(link_v_o), .link_data_o(link_data_o), .link_ready_i(link_ready_i),
        .core_v_i(core_v_i), .core_data_i(core_data_i), .core_ready_o(core_ready_o),
        .core_v_o(core_v_o), .core_data_o(core_data_o), .core_ready_i(core_ready_i),
        .mode_o(mode_o), .busy_o(busy_o), .locked_o(locked_o),
        .sent_cnt_o(sent_cnt_o), .recv_cnt_o(recv_cnt_o),
`ifdef BSG_LINK_BIST_FIRST_ERR_EN
        .first_err_v_o(first_err_v_o), .first_err_data_o(first_err_data_o),
        .first_err_exp_o(first_err_exp_o),
`endif
        .err_cnt_o(err_cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ld_o(input int ch);
        return link_data_o[ch*W +: W];
    endfunction
    function automatic logic [W-1:0] cd_o(input int ch);
        return core_data_o[ch*W +: W];
    endfunction
    function automatic logic [1:0] md_o(input int ch);
        return mode_o[ch*2 +: 2];
    endfunction
    function automatic logic [C-1:0] sent_o(input int ch);
        return sent_cnt_o[ch*C +: C];
    endfunction
    function automatic logic [C-1:0] recv_o(input int ch);
        return recv_cnt_o[ch*C +: C];
    endfunction
    function automatic logic [C-1:0] err_o(input int ch);
        return err_cnt_o[ch*C +: C];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input int ch, input logic [1:0] m);
        cfg_v_i[ch] = 1'b1;
        cfg_mode_i[ch*2 +: 2] = m;
        @(negedge clk);
        cfg_v_i[ch] = 1'b0;
        check("busy after cfg", busy_o[ch], 1'b1);
    endtask

    task automatic wait_idle(input int ch);
        int n;
        n = 0;
        while (busy_o[ch] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain bound", busy_o[ch], 1'b0);
    endtask

    task automatic drive_link(input int ch, input logic v, input logic [W-1:0] d);
        link_v_i[ch] = v;
        link_data_i[ch*W +: W] = d;
    endtask

    task automatic drive_core(input int ch, input logic v, input logic [W-1:0] d);
        core_v_i[ch] = v;
        core_data_i[ch*W +: W] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mode"}, mode_o, '0);
        check({tag, " busy"}, busy_o, '0);
        check({tag, " locked"}, locked_o, '0);
        check({tag, " link_v_o"}, link_v_o, '0);
        check({tag, " core_v_o"}, core_v_o, '0);
        check({tag, " link_ready_o"}, link_ready_o, {N{1'b1}});
        check({tag, " core_ready_o"}, core_ready_o, {N{1'b1}});
        check({tag, " link_data_o"}, (link_data_o == '0), 1'b1);
        check({tag, " core_data_o"}, (core_data_o == '0), 1'b1);
        check({tag, " counters"}, ((sent_cnt_o | recv_cnt_o | err_cnt_o) == '0), 1'b1);
    endtask

    // ---------------- PASS vector table ----------------
    typedef struct {
        logic         lv;
        logic [W-1:0] ld;
        logic         cv;
        logic [W-1:0] cd;
        logic         exp_cv;
        logic [W-1:0] exp_cd;
        logic         exp_lv;
        logic [W-1:0] exp_ld;
    } vec_t;
    vec_t tbl [6];

    // model / scratch state
    int           k, occ, accepted, emitted;
    logic         v, rdy, m_locked, m_fe_v;
    logic [W-1:0] w, m_exp, m_fe_data, m_fe_exp;
    int           m_err, m_recv;
    logic [W-1:0] chk_words [5];

    initial begin
        tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 32'hC0DE_0001, 1'b1, 32'hA5A5_0001, 1'b1, 32'hC0DE_0001};
        tbl[1] = '{1'b1, 32'hA5A5_0002, 1'b0, 32'h0,         1'b1, 32'hA5A5_0002, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h0,         1'b1, 32'hC0DE_0002, 1'b0, 32'h0,         1'b1, 32'hC0DE_0002};
        tbl[3] = '{1'b1, 32'hA5A5_0003, 1'b1, 32'hC0DE_0003, 1'b1, 32'hA5A5_0003, 1'b1, 32'hC0DE_0003};
        tbl[4] = '{1'b1, 32'hA5A5_0004, 1'b0, 32'h0,         1'b1, 32'hA5A5_0004, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        chk_words[0] = 32'h0000_0100;
        chk_words[1] = 32'h0000_0101;
        chk_words[2] = 32'h0000_DEAD;
        chk_words[3] = 32'h0000_DEAE;
        chk_words[4] = 32'h0000_DEAF;

        reset_n = 1'b0;
        cfg_v_i = '0; cfg_mode_i = '0;
        link_v_i = '0; link_data_i = '0; link_ready_i = '0;
        core_v_i = '0; core_data_i = '0; core_ready_i = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // ---- PASS, channel 0: both directions, 1-cycle latency ----
        link_ready_i[0] = 1'b1;
        core_ready_i[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_link(0, tbl[i].lv, tbl[i].ld);
            drive_core(0, tbl[i].cv, tbl[i].cd);
            @(negedge clk);
            check($sformatf("pass core_v row%0d", i), core_v_o[0], tbl[i].exp_cv);
            if (tbl[i].exp_cv) check($sformatf("pass core_data row%0d", i), cd_o(0), tbl[i].exp_cd);
            check($sformatf("pass link_v row%0d", i), link_v_o[0], tbl[i].exp_lv);
            if (tbl[i].exp_lv) check($sformatf("pass link_data row%0d", i), ld_o(0), tbl[i].exp_ld);
        end
        check("pass recv_cnt", recv_o(0), 16'd4);

        // ---- LOOP, channel 1: empty drain takes one cycle ----
        cfg_write(1, 2'd1);
        @(negedge clk);
        check("empty drain busy", busy_o[1], 1'b0);
        check("empty drain mode", md_o(1), 2'd1);

        // randomized words, link_ready_i toggling; in-flight count is the model
        exp_q.delete();
        occ = 0; accepted = 0; emitted = 0;
        for (int cyc = 0; cyc < 200 && emitted < 10; cyc++) begin
            check("loop link_ready_o", link_ready_o[1], (occ < 2));
            check("loop link_v_o", link_v_o[1], (occ > 0));
            check("loop core_v_o", core_v_o[1], 1'b0);
            check("loop core_ready_o", core_ready_o[1], 1'b0);
            rdy = cyc[0];
            if (occ > 0) begin
                check("loop data", ld_o(1), exp_q[0]);
            end
            v = (accepted < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            w = $urandom;
            drive_link(1, v, w);
            link_ready_i[1] = rdy;
            if (occ > 0 && rdy) begin
                void'(exp_q.pop_front());
                emitted++;
                occ--;
            end
            if (v && (occ + (rdy && emitted > 0 ? 0 : 0)) >= 0 && link_ready_o[1] == 1'b1 && accepted < 10) begin
                exp_q.push_back(w);
                accepted++;
            end
            occ = accepted - emitted;
            @(negedge clk);
        end
        drive_link(1, 1'b0, '0);
        check("loop words returned", emitted, 10);

        // ---- GEN, channel 0: sequential pattern from the seed ----
        link_ready_i[0] = 1'b0;
        cfg_write(0, 2'd2);
        wait_idle(0);
        k = 0;
        for (int cyc = 0; cyc < 100 && k < 6; cyc++) begin
            check("gen mode", md_o(0), 2'd2);
            check("gen link_ready_o", link_ready_o[0], 1'b0);
            check("gen core_v_o", core_v_o[0], 1'b0);
            rdy = 1'($urandom_range(0, 1));
            if (link_v_o[0] && rdy) begin
                check($sformatf("gen word %0d", k), ld_o(0), 32'h100 + k);
                k++;
            end
            link_ready_i[0] = rdy;
            @(negedge clk);
        end
        link_ready_i[0] = 1'b0;
        check("gen transfers", k, 6);
        check("gen sent_cnt", sent_o(0), 16'd6);

        // ---- drain with B full; a second write during DRAIN overrides ----
        repeat (3) @(negedge clk);
        check("gen B holds words", link_v_o[0], 1'b1);
        cfg_write(0, 2'd1);
        cfg_write(0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            check("drain busy held", busy_o[0], 1'b1);
            check("drain link_ready_o", link_ready_o[0], 1'b0);
            check("drain core_ready_o", core_ready_o[0], 1'b0);
            @(negedge clk);
        end
        link_ready_i[0] = 1'b1;
        for (int cyc = 0; cyc < 20 && busy_o[0]; cyc++) begin
            if (link_v_o[0]) begin
                check($sformatf("drain word %0d", k), ld_o(0), 32'h100 + k);
                k++;
            end
            @(negedge clk);
        end
        check("drained words", k, 8);
        check("drain done busy", busy_o[0], 1'b0);
        check("drain final mode", md_o(0), 2'd0);
        check("drain sent_cnt cleared", sent_o(0), 16'd0);
        check("drain recv_cnt cleared", recv_o(0), 16'd0);

        // ---- CHECK, channel 0: fixed sequence ----
        cfg_write(0, 2'd3);
        wait_idle(0);
        check("check locked before", locked_o[0], 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("check link_ready_o", link_ready_o[0], 1'b1);
            drive_link(0, 1'b1, chk_words[i]);
            @(negedge clk);
        end
        drive_link(0, 1'b0, '0);
        check("check locked", locked_o[0], 1'b1);
        check("check err_cnt", err_o(0), 16'd1);
        check("check recv_cnt", recv_o(0), 16'd5);
        check("check link_v_o", link_v_o[0], 1'b0);
        check("check core_v_o", core_v_o[0], 1'b0);
`ifdef BSG_LINK_BIST_FIRST_ERR_EN
        check("first err v", first_err_v_o[0], 1'b1);
        check("first err data", first_err_data_o[W-1:0], 32'h0000_DEAD);
        check("first err exp", first_err_exp_o[W-1:0], 32'h0000_0102);
`endif

        // ---- CHECK to same mode clears, then randomized against the rule model ----
        cfg_write(0, 2'd3);
        wait_idle(0);
        check("same mode locked cleared", locked_o[0], 1'b0);
        check("same mode err cleared", err_o(0), 16'd0);
        check("same mode recv cleared", recv_o(0), 16'd0);
        m_locked = 1'b0; m_exp = '0; m_err = 0; m_recv = 0;
        m_fe_v = 1'b0; m_fe_data = '0; m_fe_exp = '0;
        for (int i = 0; i < 40; i++) begin
            check("rand check ready", link_ready_o[0], 1'b1);
            v = 1'($urandom_range(0, 1));
            w = (m_locked && $urandom_range(0, 3) != 0) ? m_exp : W'($urandom);
            if (v) begin
                m_recv++;
                if (m_locked && w != m_exp) begin
                    m_err++;
                    if (!m_fe_v) begin
                        m_fe_v = 1'b1; m_fe_data = w; m_fe_exp = m_exp;
                    end
                end
                m_locked = 1'b1;
                m_exp = w + 1;
            end
            drive_link(0, v, w);
            @(negedge clk);
        end
        drive_link(0, 1'b0, '0);
        check("rand check recv", recv_o(0), C'(m_recv));
        check("rand check err", err_o(0), C'(m_err));
        check("rand check locked", locked_o[0], m_locked);
`ifdef BSG_LINK_BIST_FIRST_ERR_EN
        check("rand first err v", first_err_v_o[0], m_fe_v);
        if (m_fe_v) begin
            check("rand first err data", first_err_data_o[W-1:0], m_fe_data);
            check("rand first err exp", first_err_exp_o[W-1:0], m_fe_exp);
        end
`endif

        // ---- counter saturation, channel 2 in CHECK with a constant word ----
        cfg_write(2, 2'd3);
        wait_idle(2);
        drive_link(2, 1'b1, 32'h5A5A_5A5A);
        repeat (65540) @(negedge clk);
        drive_link(2, 1'b0, '0);
        @(negedge clk);
        check("sat recv_cnt", recv_o(2), 16'hFFFF);
        check("sat err_cnt", err_o(2), 16'hFFFF);

        // ---- reset in the middle of a drain with both FIFOs full ----
        cfg_write(0, 2'd0);
        wait_idle(0);
        link_ready_i[0] = 1'b0;
        core_ready_i[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_link(0, 1'b1, 32'h1111_0000 + i);
            drive_core(0, 1'b1, 32'h2222_0000 + i);
            @(negedge clk);
        end
        drive_link(0, 1'b0, '0);
        drive_core(0, 1'b0, '0);
        check("full A blocks link_ready_o", link_ready_o[0], 1'b0);
        check("full B blocks core_ready_o", core_ready_o[0], 1'b0);
        cfg_write(0, 2'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid-drain reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post reset mode", md_o(0), 2'd0);
        check("post reset link_v_o", link_v_o, '0);
        check("post reset core_v_o", core_v_o, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
